// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_if
//  Description : Start/done handshake and operand/result bundle for the
//                serial_adder. The sub signal exists only when
//                SERIAL_ADDER_SUB_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Multi-cycle adder processing DIGIT bits of two WIDTH-bit
//                operands per clock with a registered inter-digit carry.
//                Optional subtract mode enabled by defining
//                SERIAL_ADDER_SUB_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    serial_adder_if.slave bus
);

    localparam int c_digits = WIDTH / DIGIT;
    localparam int c_cnt_w  = (c_digits > 1) ? $clog2(c_digits) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_digits - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_c_in;
    logic [DIGIT:0]     w_dsum;
    logic               w_msb_cin;
    logic [WIDTH-1:0]   w_acc_next;

    // A start is only honoured when no operation is in flight
    assign w_accept = bus.start && ((r_state == c_idle) || (r_state == c_done));
    assign w_last   = (r_state == c_run) && (r_cnt == c_last_cnt);

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as a + ~b + 1; cin is ignored in that mode
    assign w_b_in = bus.sub ? ~bus.b : bus.b;
    assign w_c_in = bus.sub ? 1'b1   : bus.cin;
`else
    assign w_b_in = bus.b;
    assign w_c_in = bus.cin;
`endif

    // One digit of ripple addition on the low bits of the shift registers
    assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};

    // Carry into the digit's top bit recovered from that bit's sum equation;
    // on the final digit this is the carry into bit WIDTH-1
    assign w_msb_cin = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];

    // Result digits enter from the MSB end; once all digits are in, the
    // assembled word is aligned and goes straight to the sum register
    generate
        if (DIGIT == WIDTH) begin : g_acc_single
            assign w_acc_next = w_dsum[DIGIT-1:0];
        end else begin : g_acc_shift
            // Holds the first N-1 digits; the last digit never needs storing
            logic [WIDTH-DIGIT-1:0] r_acc;

            assign w_acc_next = {w_dsum[DIGIT-1:0], r_acc};

            // Shift partial result toward the LSB as each digit completes
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (r_state == c_run) begin
                    r_acc <= w_acc_next[WIDTH-1:DIGIT];
                end
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: start is ignored while running
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (bus.start) w_next_state = c_run;
            c_run:   if (r_cnt == c_last_cnt) w_next_state = c_done;
            c_done:  w_next_state = bus.start ? c_run : c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // Moore handshake outputs decoded from state
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            c_run:   bus.busy = 1'b1;
            c_done:  bus.done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, digit-serial datapath and result publication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= w_b_in;
            r_carry <= w_c_in;
            r_cnt   <= '0;
        end else if (r_state == c_run) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_dsum[DIGIT];
            r_cnt   <= r_cnt + c_cnt_w'(1);
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_dsum[DIGIT];
                r_ovf  <= w_msb_cin ^ w_dsum[DIGIT];
            end
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire
